pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 13 +
 rtl/pwm_step_calc.sv | 32 +++
 rtl/pwm_ramp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared state encoding and default widths for the PWM ramp controller
package pwm_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PPS_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RAMP = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_step_calc.sv
// rtl/pwm_step_calc.sv - combinational saturating duty stepper, moves cur one step toward tgt
module pwm_step_calc
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] tgt,
    input  logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] nxt
);

    localparam logic [CNT_W:0] ONE_X = {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W:0] step_eff;
    logic [CNT_W:0] up_sum;
    logic [CNT_W:0] dn_diff;

    // One extra bit so neither direction can wrap past the ends of the range.
    always_comb begin
        step_eff = (step == '0) ? ONE_X : {1'b0, step};
        up_sum   = {1'b0, cur} + step_eff;
        dn_diff  = {1'b0, cur} - step_eff;
        nxt      = cur;
        if (tgt > cur) begin
            nxt = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[CNT_W-1:0];
        end else if (tgt < cur) begin
            nxt = (dn_diff[CNT_W] || (dn_diff <= {1'b0, tgt})) ? tgt : dn_diff[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - PWM counter with shadowed period and duty ramping; PWM_RAMP_CTRL_SOFTSTART_EN ramps from 0 on run
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PPS_W = PPS_W_DEF
) (
    input  logic             chosen_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] target_dc,
    input  logic [CNT_W-1:0] step,
    input  logic [PPS_W-1:0] pps,
    input  logic             load,
    output logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] period_reg,
    output logic [CNT_W-1:0] dc_out,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PPS_W:0]   PPS_ONE = {{PPS_W{1'b0}}, 1'b1};
    localparam logic [PPS_W-1:0] WC_ONE  = {{(PPS_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] dc_q, dc_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [PPS_W-1:0] wcnt_q, wcnt_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             running;
    logic             last;
    logic [CNT_W-1:0] tgt_new;
    logic [CNT_W-1:0] step_nxt;
    logic [PPS_W:0]   pps_eff;
    logic             pps_hit;

    assign running = (state_q != IDLE);
    assign last    = running && ((period_q == '0) || (cnt_q == period_q - ONE));
    // A load in the same cycle as a step must already steer that step.
    assign tgt_new = load ? target_dc : tgt_q;
    assign pps_eff = (pps == '0) ? PPS_ONE : {1'b0, pps};
    assign pps_hit = (({1'b0, wcnt_q} + PPS_ONE) >= pps_eff);

    pwm_step_calc #(
        .CNT_W(CNT_W)
    ) u_step (
        .cur (dc_q),
        .tgt (tgt_new),
        .step(step),
        .nxt (step_nxt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        dc_d     = dc_q;
        tgt_d    = tgt_q;
        wcnt_d   = wcnt_q;
        done_d   = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            wcnt_d  = '0;
            if (state_q == IDLE) begin
                tgt_d = tgt_new;
            end
        end else begin
            tgt_d = tgt_new;
            if (running) begin
                if (last) begin
                    cnt_d    = '0;
                    period_d = period_in;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            case (state_q)
                IDLE: begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    period_d = period_in;
                    wcnt_d   = '0;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
                    dc_d = '0;
                    if (tgt_new != '0) begin
                        state_d = RAMP;
                    end
`endif
                end
                HOLD: begin
                    wcnt_d = '0;
                    if (load && (target_dc != dc_q)) begin
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    if (last) begin
                        if (pps_hit) begin
                            dc_d   = step_nxt;
                            wcnt_d = '0;
                        end else begin
                            wcnt_d = wcnt_q + WC_ONE;
                        end
                    end
                    if (dc_d == tgt_new) begin
                        state_d = HOLD;
                        wcnt_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        wrap_d = (state_d != IDLE) && ((period_d == '0) || (cnt_d == period_d - ONE));
        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge chosen_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            dc_q     <= '0;
            tgt_q    <= '0;
            wcnt_q   <= '0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            dc_q     <= dc_d;
            tgt_q    <= tgt_d;
            wcnt_q   <= wcnt_d;
            wrap_q   <= wrap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign counter    = cnt_q;
    assign period_reg = period_q;
    assign dc_out     = dc_q;
    assign wrap       = wrap_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl; honours PWM_RAMP_CTRL_SOFTSTART_EN
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

    localparam int CNT_W = 16;
    localparam int PPS_W = 8;

    logic             chosen_clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] target_dc;
    logic [CNT_W-1:0] step;
    logic [PPS_W-1:0] pps;
    logic             load;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] dc_out;
    logic             wrap;
    logic             busy;
    logic             done;

    pwm_ramp_ctrl #(.CNT_W(CNT_W), .PPS_W(PPS_W)) dut (
        .chosen_clk(chosen_clk),
        .rst_n     (rst_n),
        .en        (en),
        .period_in (period_in),
        .target_dc (target_dc),
        .step      (step),
        .pps       (pps),
        .load      (load),
        .counter   (counter),
        .period_reg(period_reg),
        .dc_out    (dc_out),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    always #5 chosen_clk = ~chosen_clk;

    typedef struct {
        int dc;
        int wraps;
    } step_t;

    step_t            exp_q[$];
    int               done_q[$];
    step_t            mon_e;
    step_t            tmp_e;
    int               mon_d;
    int               n_checks = 0;
    int               n_pass = 0;
    int               model_dc = 0;
    int               wraps_seen = 0;
    int               dc_changes = 0;
    logic [CNT_W-1:0] prev_dc = '0;
    bit               mon_on = 1'b0;
    int               exp_cnt39 [9] = '{2, 3, 0, 1, 2, 3, 4, 5, 0};
    int               exp_wrap39 [9] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Expected duty trajectory: each step moves by max(step,1), clipped at the target.
    function automatic void plan_ramp(int from, int to, int st, int pp);
        int cur = from;
        int s = (st == 0) ? 1 : st;
        int pe = (pp == 0) ? 1 : pp;
        step_t e;
        while (cur != to) begin
            if (to > cur) cur = (cur + s >= to) ? to : cur + s;
            else          cur = (cur - s <= to) ? to : cur - s;
            e.dc = cur;
            e.wraps = pe;
            exp_q.push_back(e);
        end
        if (from != to) done_q.push_back(to);
    endfunction

    always @(negedge chosen_clk) begin
        if (mon_on) begin
            if (dc_out != prev_dc) begin
                if (exp_q.size() == 0) begin
                    check("dc_unexpected_change", int'(dc_out), int'(prev_dc));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dc_step_value", int'(dc_out), mon_e.dc);
                    check("wraps_per_step", wraps_seen, mon_e.wraps);
                    model_dc = mon_e.dc;
                end
                wraps_seen = 0;
                dc_changes++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_dc", int'(dc_out), mon_d);
                    check("done_busy_low", int'(busy), 0);
                end
            end
            if (busy && wrap) wraps_seen++;
        end
        prev_dc = dc_out;
    end

    task automatic tick();
        @(negedge chosen_clk);
        #1;
    endtask

    task automatic pulse_load(int tgt);
        target_dc = CNT_W'(tgt);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic start_ramp(int tgt, int st, int pp);
        step = CNT_W'(st);
        pps = PPS_W'(pp);
        wraps_seen = 0;
        plan_ramp(model_dc, tgt, st, pp);
        pulse_load(tgt);
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_completes"}, int'(exp_q.size() == 0 && done_q.size() == 0), 1);
        repeat (2) tick();
    endtask

    task automatic wait_dc_change(int budget);
        int start = dc_changes;
        int n = 0;
        while (dc_changes == start && n < budget) begin
            tick();
            n++;
        end
        check("dc_change_seen", int'(dc_changes != start), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, tgt, diff, st, pp, n, sel, new_tgt;
        rst_n = 1'b1; en = 1'b0; load = 1'b0; period_in = 16'd4;
        target_dc = '0; step = '0; pps = '0;
        #3 rst_n = 1'b0;
        #3;
        check("reset_counter", int'(counter), 0);
        check("reset_period_reg", int'(period_reg), 0);
        check("reset_dc_out", int'(dc_out), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge chosen_clk);
        rst_n = 1'b1;
        tick();
        check("idle_counter", int'(counter), 0);
        mon_on = 1'b1;

        en = 1'b1;
        tick();
        check("hold_period_reg", int'(period_reg), 4);
        for (int k = 0; k < 9; k++) begin
            check("cnt_p4", int'(counter), k % 4);
            check("wrap_p4", int'(wrap), int'(k % 4 == 3));
            tick();
        end

        n = 0;
        while (counter != 16'd1 && n < 10) begin tick(); n++; end
        check("p4_sync_counter1", int'(counter), 1);
        period_in = 16'd6;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("cnt_p4_to_p6", int'(counter), exp_cnt39[k]);
            check("wrap_p4_to_p6", int'(wrap), exp_wrap39[k]);
        end
        check("period_reg_6", int'(period_reg), 6);

        start_ramp(25, 10, 2);
        wait_idle("ramp_0_to_25", 2000);
        check("after_25_busy", int'(busy), 0);
        check("after_25_done", int'(done), 0);

        start_ramp(100, 100, 1);
        wait_idle("ramp_to_100", 500);
        start_ramp(98, 0, 0);
        wait_idle("ramp_100_to_98", 500);

        for (int it = 0; it < 12; it++) begin
            p = int'($urandom_range(0, 7));
            period_in = CNT_W'(p);
            repeat (10) tick();
            sel = int'($urandom_range(0, 3));
            if (it == 0)       tgt = model_dc;
            else if (sel == 0) tgt = 0;
            else if (sel == 1) tgt = 65535;
            else               tgt = int'($urandom_range(0, 65535));
            diff = (tgt > model_dc) ? tgt - model_dc : model_dc - tgt;
            st = diff / int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) st = st + int'($urandom_range(0, 40));
            if (st > 65535) st = 65535;
            pp = int'($urandom_range(0, 3));
            if (tgt == model_dc) begin
                start_ramp(tgt, st, pp);
                tick();
                check("load_equal_stays_hold", int'(busy), 0);
            end else begin
                start_ramp(tgt, st, pp);
                wait_idle("random_ramp", 3000);
            end
        end

        period_in = 16'd3;
        repeat (20) tick();
        start_ramp(1000, 1000, 1);
        wait_idle("ramp_to_1000", 500);
        start_ramp(1050, 5, 3);
        wait_dc_change(500);
        n = 0;
        while (wraps_seen < 1 && n < 100) begin tick(); n++; end
        check("retarget_wrap_seen", int'(wraps_seen >= 1), 1);
        new_tgt = model_dc - 12;
        exp_q.delete();
        done_q.delete();
        plan_ramp(model_dc, new_tgt, 5, 3);
        pulse_load(new_tgt);
        wait_idle("retarget_reverse", 2000);

        start_ramp(model_dc + 40, 5, 3);
        wait_dc_change(500);
        exp_q.delete();
        done_q.delete();
        done_q.push_back(model_dc);
        pulse_load(model_dc);
        wait_idle("load_equal_in_ramp", 200);
        check("load_equal_busy", int'(busy), 0);

        start_ramp(model_dc + 30, 3, 1);
        wait_dc_change(500);
        en = 1'b0;
        exp_q.delete();
        done_q.delete();
        tick();
        check("en0_counter", int'(counter), 0);
        check("en0_busy", int'(busy), 0);
        check("en0_wrap", int'(wrap), 0);
        check("en0_dc_held", int'(dc_out), model_dc);
        check("en0_done", int'(done), 0);
        repeat (3) tick();
        check("idle_counter_stays", int'(counter), 0);
        step = 16'd15;
        pps = 8'd1;
        pulse_load(30);
        tick();
        check("idle_load_busy", int'(busy), 0);
        check("idle_load_counter", int'(counter), 0);
        check("idle_load_dc", int'(dc_out), model_dc);
        wraps_seen = 0;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        if (model_dc != 0) begin
            tmp_e.dc = 0;
            tmp_e.wraps = 0;
            exp_q.push_back(tmp_e);
        end
        plan_ramp(0, 30, 15, 1);
        en = 1'b1;
        wait_idle("softstart_0_to_30", 500);
`else
        en = 1'b1;
        repeat (4) tick();
        check("run_keeps_dc", int'(dc_out), model_dc);
        check("run_hold_busy", int'(busy), 0);
        start_ramp(30, 15, 1);
        wait_idle("ramp_to_30", 2000);
`endif

        start_ramp(model_dc + 20, 5, 2);
        wait_dc_change(500);
        mon_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_counter", int'(counter), 0);
        check("async_rst_period_reg", int'(period_reg), 0);
        check("async_rst_dc_out", int'(dc_out), 0);
        check("async_rst_wrap", int'(wrap), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        exp_q.delete();
        done_q.delete();
        model_dc = 0;
        wraps_seen = 0;
        @(negedge chosen_clk);
        rst_n = 1'b1;
        repeat (2) tick();
        mon_on = 1'b1;
        repeat (4) tick();
        check("post_reset_dc", int'(dc_out), 0);
        check("post_reset_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
